seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative restoring divider for the ALU; the inverse datapath of the sequential multiplier.
- Accepts a WIDTH-bit dividend and divisor on a start pulse and produces one quotient bit per cycle.
- Returns quotient and remainder with a one-cycle done pulse.
- Sits beside the multiplier under the ALU and shares its start/busy/done handshake, so the ALU sequencer drives both identically.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
signed_op  input  1  1 = two's-complement operands, 0 = unsigned
dividend  input  WIDTH  numerator, sampled with start
divisor  input  WIDTH  denominator, sampled with start
busy  output  1  high from the start-accept edge until the done edge
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  result quotient, held until the next done
remainder  output  WIDTH  result remainder, held until the next done
div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, div_by_zero, quotient, remainder, counter and internal registers = 0. Reset mid-operation aborts the operation; no done is issued.
- States: IDLE, RUN, FIX.
- IDLE with start=1 at edge E0:
  - latch |dividend| and |divisor|; magnitude is taken only if signed_op=1, else raw values;
  - record neg_q = signed_op & (dividend[MSB] ^ divisor[MSB]) and neg_r = signed_op & dividend[MSB];
  - record the raw dividend;
  - busy=1; counter=WIDTH;
  - next state = RUN, or FIX directly if divisor==0.
- RUN, each edge:
  - partial remainder P (WIDTH+1 bits) shifts left, taking the next dividend MSB;
  - trial = P - divisor;
  - if trial is non-negative, P=trial and the quotient bit is 1; else P is kept and the quotient bit is 0;
  - counter decrements; at counter==1, next state = FIX.
- FIX, one edge:
  - quotient = neg_q ? -Q : Q; remainder = neg_r ? -P : P;
  - done=1, busy=0, state=IDLE.
- Latency: done is high in the cycle following edge E0+WIDTH+1, i.e. WIDTH+2 edges after start. For divide-by-zero it is 2 edges.
- Divide by zero: quotient = all ones, remainder = raw dividend, div_by_zero=1. This applies in both signed and unsigned modes.
- Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0, div_by_zero=0. This falls out of the magnitude arithmetic; no special case is needed.
- Sign rules: quotient truncates toward zero; remainder takes the sign of the dividend; a zero result is never negated to a nonzero value.
- start while busy=1 is ignored; operands are not re-sampled.
- Back-to-back: start asserted in the done cycle (state already IDLE) is accepted. The new operation then runs with busy=1 on the next cycle.
- done is high for exactly one cycle. div_by_zero and the results hold until the next done or reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Unsigned 100 / 7 with start for one cycle → quotient=14, remainder=2, div_by_zero=0, done exactly 34 edges after the start edge, busy high for 33 cycles.
- Signed -100 / 7 → quotient=0xFFFFFFF2, remainder=0xFFFFFFFE; signed 100 / -7 → quotient=0xFFFFFFF2, remainder=2.
- 0x12345678 / 0, both modes → quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, done 2 edges after start.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, div_by_zero=0.
- Unsigned 0xFFFFFFFF / 1 and 5 / 9 → (0xFFFFFFFF, 0) and (0, 5).
- Robustness:
  - Pulse start with new operands at cycle 10 of a busy run → ignored; the original result returns.
  - Start in the done cycle → second result arrives 34 edges later.
  - Drop rst at cycle 15 → busy, done and results go to 0 immediately; no done follows.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring divider (signed/unsigned), one quotient bit per cycle.
// Latency: done WIDTH+2 edges after the start edge (2 for divide-by-zero).
// No backpressure: start is accepted only in IDLE and ignored while busy.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;      // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] raw_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo;
    logic             neg_rem;
    logic             dz_q;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   trial;

    assign dvd_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Partial remainder is always below the divisor, so WIDTH bits hold it
    // and the shifted value needs just one extra bit for the trial subtract.
    assign p_shift = {p_q, a_q[WIDTH-1]};
    assign trial   = p_shift - {1'b0, b_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            raw_q       <= '0;
            cnt_q       <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            dz_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= dvd_mag;
                        b_q     <= dvs_mag;
                        p_q     <= '0;
                        raw_q   <= dividend;
                        neg_quo <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem <= signed_op & dividend[WIDTH-1];
                        dz_q    <= (divisor == '0);
                        cnt_q   <= CNT_W'(WIDTH);
                        busy    <= 1'b1;
                        state   <= (divisor == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        p_q <= trial[WIDTH-1:0];
                        a_q <= {a_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_q <= p_shift[WIDTH-1:0];
                        a_q <= {a_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    if (dz_q) begin
                        quotient  <= '1;
                        remainder <= raw_q;
                    end else begin
                        quotient  <= neg_quo ? -a_q : a_q;
                        remainder <= neg_rem ? -p_q : p_q;
                    end
                    div_by_zero <= dz_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: result table plus handshake corner cases.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dz;
        int          exp_edges;
        int          exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Called at a negedge; the next posedge is the start edge.
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        signed_op = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Counts edges from the start edge (counted as 1) to the edge that raises done.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
            if (busy) busy_cnt++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL timeout: no done after %0d edges, expected one", edges);
        end
    endtask

    int edges, bcnt;

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 34, 33};
        vecs[1] = '{1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34, 33};
        vecs[2] = '{1'b1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 34, 33};
        vecs[3] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 34, 33};
        vecs[4] = '{1'b0, 32'h12345678,   32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1, 2,  1};
        vecs[5] = '{1'b1, 32'h12345678,   32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1, 2,  1};
        vecs[6] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34, 33};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 34, 33};
        vecs[8] = '{1'b0, 32'd5,          32'd9,        32'd0,        32'd5,        1'b0, 34, 33};
        vecs[9] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 34, 33};

        // Reset state
        #2;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].sgn, vecs[i].dvd, vecs[i].dvs);
            wait_done(edges, bcnt);
            check($sformatf("v%0d_q", i), quotient, vecs[i].exp_q);
            check($sformatf("v%0d_r", i), remainder, vecs[i].exp_r);
            check($sformatf("v%0d_dz", i), {31'b0, div_by_zero}, {31'b0, vecs[i].exp_dz});
            check($sformatf("v%0d_edges", i), edges, vecs[i].exp_edges);
            check($sformatf("v%0d_busy", i), bcnt, vecs[i].exp_busy);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
            check($sformatf("v%0d_hold_q", i), quotient, vecs[i].exp_q);
        end

        // Start while busy is ignored
        launch(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        launch(1'b1, 32'd50, 32'hFFFFFFFB);
        wait_done(edges, bcnt);
        check("busy_start_q", quotient, 32'd14);
        check("busy_start_r", remainder, 32'd2);
        check("busy_start_edges", edges + 10, 32'd34);
        @(negedge clk);
        repeat (40) begin
            @(negedge clk);
            if (done) begin
                n_checks++;
                $display("FAIL busy_start_extra_done: got done=1, expected 0");
            end
        end

        // Back-to-back: start in the done cycle
        launch(1'b0, 32'd1000, 32'd10);
        wait_done(edges, bcnt);
        check("b2b_first_q", quotient, 32'd100);
        launch(1'b0, 32'd77, 32'd8);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        check("b2b_done_low", {31'b0, done}, 32'd0);
        wait_done(edges, bcnt);
        check("b2b_q", quotient, 32'd9);
        check("b2b_r", remainder, 32'd5);
        check("b2b_edges", edges, 32'd34);

        // Reset mid-operation
        @(negedge clk);
        launch(1'b0, 32'd12345, 32'd3);
        repeat (13) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_q", quotient, 32'd0);
        check("midrst_r", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) bcnt++;
        end
        check("midrst_no_done", bcnt, 32'd0);

        // Recovers after reset
        launch(1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done(edges, bcnt);
        check("post_rst_q", quotient, 32'hFFFFFFFD);
        check("post_rst_r", remainder, 32'hFFFFFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
